// File: rtl/ysyx_22040632_cache_axi_arbiter.sv
// Two-to-one arbiter for the shared rw_* master port. The icache and dcache
// compete for it with round-robin priority. A grant is held for the whole
// transaction and released in the cycle after m_ready.
module ysyx_22040632_cache_axi_arbiter #(
    parameter int AW = 32,
    parameter int DW = 64
) (
    input  logic            clk,
    input  logic            rrst_n,
    // icache request side
    input  logic            i_valid,
    input  logic            i_req,
    input  logic [AW-1:0]   i_addr,
    input  logic [2:0]      i_size,
    input  logic [7:0]      i_len,
    input  logic [DW-1:0]   i_wdata,
    input  logic [DW/8-1:0] i_wstrb,
    input  logic            i_wlast,
    output logic            i_ready,
    output logic [DW-1:0]   i_rdata,
    output logic            i_rhs,
    output logic            i_rlast,
    output logic            i_whs,
    // dcache request side
    input  logic            d_valid,
    input  logic            d_req,
    input  logic [AW-1:0]   d_addr,
    input  logic [2:0]      d_size,
    input  logic [7:0]      d_len,
    input  logic [DW-1:0]   d_wdata,
    input  logic [DW/8-1:0] d_wstrb,
    input  logic            d_wlast,
    output logic            d_ready,
    output logic [DW-1:0]   d_rdata,
    output logic            d_rhs,
    output logic            d_rlast,
    output logic            d_whs,
    // downstream master port
    output logic            m_valid,
    output logic            m_req,
    output logic [AW-1:0]   m_addr,
    output logic [2:0]      m_size,
    output logic [7:0]      m_len,
    output logic [DW-1:0]   m_wdata,
    output logic [DW/8-1:0] m_wstrb,
    output logic            m_wlast,
    input  logic            m_ready,
    input  logic [DW-1:0]   m_rdata,
    input  logic            m_rhs,
    input  logic            m_rlast,
    input  logic            m_whs,
    output logic            busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    state_t state;
    owner_t last_gnt;

    // Grant FSM: arbitrate only in IDLE, hold the grant until m_ready,
    // then pass through IDLE so a waiting requester gets its turn.
    always_ff @(posedge clk or negedge rrst_n) begin
        if (!rrst_n) begin
            state    <= IDLE;
            last_gnt <= OWN_I;
        end else begin
            case (state)
                IDLE: begin
                    if (d_valid && (!i_valid || last_gnt == OWN_I)) begin
                        state <= GNT_D;
                    end else if (i_valid) begin
                        state <= GNT_I;
                    end
                end
                GNT_I: begin
                    if (m_ready) begin
                        state    <= IDLE;
                        last_gnt <= OWN_I;
                    end
                end
                GNT_D: begin
                    if (m_ready) begin
                        state    <= IDLE;
                        last_gnt <= OWN_D;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Request and response muxing keyed on the registered grant; since the
    // grant resets asynchronously to IDLE, every output drops with reset.
    always_comb begin
        m_valid = 1'b0;
        m_req   = 1'b0;
        m_addr  = '0;
        m_size  = '0;
        m_len   = '0;
        m_wdata = '0;
        m_wstrb = '0;
        m_wlast = 1'b0;
        i_ready = 1'b0;
        i_rdata = '0;
        i_rhs   = 1'b0;
        i_rlast = 1'b0;
        i_whs   = 1'b0;
        d_ready = 1'b0;
        d_rdata = '0;
        d_rhs   = 1'b0;
        d_rlast = 1'b0;
        d_whs   = 1'b0;
        case (state)
            GNT_I: begin
                m_valid = i_valid;
                m_req   = i_req;
                m_addr  = i_addr;
                m_size  = i_size;
                m_len   = i_len;
                m_wdata = i_wdata;
                m_wstrb = i_wstrb;
                m_wlast = i_wlast;
                i_ready = m_ready;
                i_rdata = m_rdata;
                i_rhs   = m_rhs;
                i_rlast = m_rlast;
                i_whs   = m_whs;
            end
            GNT_D: begin
                m_valid = d_valid;
                m_req   = d_req;
                m_addr  = d_addr;
                m_size  = d_size;
                m_len   = d_len;
                m_wdata = d_wdata;
                m_wstrb = d_wstrb;
                m_wlast = d_wlast;
                d_ready = m_ready;
                d_rdata = m_rdata;
                d_rhs   = m_rhs;
                d_rlast = m_rlast;
                d_whs   = m_whs;
            end
            default: ;
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_ysyx_22040632_cache_axi_arbiter.sv
// Bench for the icache/dcache arbiter: directed scenarios followed by a
// randomized soak, all checked against a transaction-level ownership model.
module tb_ysyx_22040632_cache_axi_arbiter;

    localparam int AW = 32;
    localparam int DW = 64;

    logic clk = 1'b0;
    logic rrst_n;
    logic i_valid, i_req, i_wlast, d_valid, d_req, d_wlast;
    logic [AW-1:0] i_addr, d_addr;
    logic [2:0] i_size, d_size;
    logic [7:0] i_len, d_len;
    logic [DW-1:0] i_wdata, d_wdata;
    logic [DW/8-1:0] i_wstrb, d_wstrb;
    logic i_ready, i_rhs, i_rlast, i_whs, d_ready, d_rhs, d_rlast, d_whs;
    logic [DW-1:0] i_rdata, d_rdata;
    logic m_valid, m_req, m_wlast, m_ready, m_rhs, m_rlast, m_whs, busy;
    logic [AW-1:0] m_addr;
    logic [2:0] m_size;
    logic [7:0] m_len;
    logic [DW-1:0] m_wdata, m_rdata;
    logic [DW/8-1:0] m_wstrb;

    ysyx_22040632_cache_axi_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rrst_n(rrst_n),
        .i_valid(i_valid), .i_req(i_req), .i_addr(i_addr), .i_size(i_size),
        .i_len(i_len), .i_wdata(i_wdata), .i_wstrb(i_wstrb), .i_wlast(i_wlast),
        .i_ready(i_ready), .i_rdata(i_rdata), .i_rhs(i_rhs), .i_rlast(i_rlast),
        .i_whs(i_whs),
        .d_valid(d_valid), .d_req(d_req), .d_addr(d_addr), .d_size(d_size),
        .d_len(d_len), .d_wdata(d_wdata), .d_wstrb(d_wstrb), .d_wlast(d_wlast),
        .d_ready(d_ready), .d_rdata(d_rdata), .d_rhs(d_rhs), .d_rlast(d_rlast),
        .d_whs(d_whs),
        .m_valid(m_valid), .m_req(m_req), .m_addr(m_addr), .m_size(m_size),
        .m_len(m_len), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
        .m_ready(m_ready), .m_rdata(m_rdata), .m_rhs(m_rhs), .m_rlast(m_rlast),
        .m_whs(m_whs), .busy(busy)
    );

    always #5 clk = ~clk;

    int tests  = 0;
    int failed = 0;

    // Reference model: who owns the port (0 nobody, 1 icache, 2 dcache) and
    // who owned it last. Reset leaves "last" at icache so dcache wins a tie.
    int owner = 0;
    int last  = 1;
    int i_rhs_cnt, i_ready_cnt, d_rhs_cnt, d_ready_cnt, d_whs_cnt;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [127:0] exp_m, exp_i, exp_d, resp;
        resp  = {m_ready, m_rdata, m_rhs, m_rlast, m_whs};
        exp_m = '0;
        exp_i = '0;
        exp_d = '0;
        if (owner == 1) begin
            exp_m = {i_valid, i_req, i_addr, i_size, i_len, i_wdata, i_wstrb, i_wlast};
            exp_i = resp;
        end else if (owner == 2) begin
            exp_m = {d_valid, d_req, d_addr, d_size, d_len, d_wdata, d_wstrb, d_wlast};
            exp_d = resp;
        end
        chk("m_bus", {m_valid, m_req, m_addr, m_size, m_len, m_wdata, m_wstrb, m_wlast}, exp_m);
        chk("i_resp", {i_ready, i_rdata, i_rhs, i_rlast, i_whs}, exp_i);
        chk("d_resp", {d_ready, d_rdata, d_rhs, d_rlast, d_whs}, exp_d);
        chk("busy", 128'(busy), 128'(owner != 0));
    endtask

    // One cycle: check settled outputs, advance the model at the edge,
    // return at the falling edge ready for new stimulus.
    task automatic step();
        #1;
        check_all();
        i_rhs_cnt   += int'(i_rhs);
        i_ready_cnt += int'(i_ready);
        d_rhs_cnt   += int'(d_rhs);
        d_ready_cnt += int'(d_ready);
        d_whs_cnt   += int'(d_whs);
        @(posedge clk);
        if (owner == 0) begin
            if (i_valid && d_valid) owner = 3 - last;
            else if (d_valid)       owner = 2;
            else if (i_valid)       owner = 1;
        end else if (m_ready) begin
            last  = owner;
            owner = 0;
        end
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        i_valid = 0; i_req = 0; i_addr = '0; i_size = '0; i_len = '0;
        i_wdata = '0; i_wstrb = '0; i_wlast = 0;
        d_valid = 0; d_req = 0; d_addr = '0; d_size = '0; d_len = '0;
        d_wdata = '0; d_wstrb = '0; d_wlast = 0;
        m_ready = 0; m_rdata = '0; m_rhs = 0; m_rlast = 0; m_whs = 0;
    endtask

    task automatic clear_counts();
        i_rhs_cnt = 0; i_ready_cnt = 0; d_rhs_cnt = 0; d_ready_cnt = 0; d_whs_cnt = 0;
    endtask

    initial begin
        clear_inputs();
        clear_counts();
        rrst_n = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_busy", 128'(busy), 128'(0));
        chk("reset_m_valid", 128'(m_valid), 128'(0));
        rrst_n = 1;
        @(negedge clk);

        // 1: icache read burst of 8 beats
        i_valid = 1; i_req = 0; i_addr = 32'h3000_0040; i_size = 3'd3; i_len = 8'd7;
        step();
        chk("t1_granted_i", 128'(m_addr), 128'(32'h3000_0040));
        for (int b = 1; b <= 8; b++) begin
            m_rhs = 1; m_rlast = (b == 8); m_rdata = {$urandom, $urandom};
            step();
        end
        m_rhs = 0; m_rlast = 0; m_ready = 1;
        step();
        m_ready = 0; i_valid = 0;
        step();
        chk("t1_i_rhs_cnt", 128'(i_rhs_cnt), 128'(8));
        chk("t1_i_ready_cnt", 128'(i_ready_cnt), 128'(1));
        chk("t1_d_silent", 128'(d_rhs_cnt + d_ready_cnt), 128'(0));
        chk("t1_idle", 128'(busy), 128'(0));

        // 2: tie after reset goes to dcache, then icache, then dcache again
        rrst_n = 0; #1; owner = 0; last = 1; rrst_n = 1;
        @(negedge clk);
        i_valid = 1; i_addr = 32'h0000_1000; d_valid = 1; d_addr = 32'h0000_2000;
        step();
        chk("t2_first_d", 128'(m_addr), 128'(32'h0000_2000));
        m_ready = 1; step(); m_ready = 0;
        step();
        chk("t2_then_i", 128'(m_addr), 128'(32'h0000_1000));
        m_ready = 1; step(); m_ready = 0;
        step();
        chk("t2_tie_d", 128'(m_addr), 128'(32'h0000_2000));
        m_ready = 1; step(); m_ready = 0;
        clear_inputs();
        step(); // icache wins the IDLE cycle only if valid; it is not, so stay idle
        step();

        // 3: dcache write burst, icache arrives mid-burst
        clear_counts();
        d_valid = 1; d_req = 1; d_addr = 32'h8000_1000; d_size = 3'd3; d_len = 8'd7;
        d_wstrb = 8'hff;
        step();
        for (int b = 1; b <= 8; b++) begin
            d_wdata = {$urandom, $urandom}; d_wlast = (b == 8); m_whs = 1;
            if (b == 4) begin i_valid = 1; i_addr = 32'h3000_0100; end
            step();
            chk("t3_addr_locked", 128'(m_addr), 128'(32'h8000_1000));
            chk("t3_i_ready_low", 128'(i_ready), 128'(0));
        end
        m_whs = 0; d_wlast = 0; m_ready = 1;
        step();
        m_ready = 0; d_valid = 0;
        step();
        chk("t3_whs_cnt", 128'(d_whs_cnt), 128'(8));
        chk("t3_then_i", 128'(m_addr), 128'(32'h3000_0100));
        m_ready = 1; step(); clear_inputs(); step();

        // 4: single-beat byte write, uncacheable
        clear_counts();
        d_valid = 1; d_req = 1; d_addr = 32'h1000_0000; d_size = 3'd0; d_len = 8'd0;
        d_wstrb = 8'h01; d_wdata = 64'h41; d_wlast = 1;
        step();
        chk("t4_m_size", 128'(m_size), 128'(0));
        chk("t4_m_len", 128'(m_len), 128'(0));
        chk("t4_m_wstrb", 128'(m_wstrb), 128'(8'h01));
        m_whs = 1; step(); m_whs = 0;
        m_ready = 1; step();
        clear_inputs(); step();
        chk("t4_d_ready_cnt", 128'(d_ready_cnt), 128'(1));

        // 5: reset during dcache beat 3; last grant is dcache at this point
        d_valid = 1; d_req = 0; d_addr = 32'h8000_2000; d_len = 8'd7;
        step();
        for (int b = 1; b <= 2; b++) begin m_rhs = 1; step(); end
        m_rhs = 1;
        #2;
        rrst_n = 0;
        #1;
        chk("t5_m_valid", 128'(m_valid), 128'(0));
        chk("t5_busy", 128'(busy), 128'(0));
        chk("t5_d_rhs", 128'(d_rhs), 128'(0));
        owner = 0; last = 1;
        @(negedge clk);
        rrst_n = 1; m_rhs = 0;
        i_valid = 1; i_addr = 32'h0000_3000; d_valid = 1; d_addr = 32'h0000_4000;
        step();
        chk("t5_tie_d", 128'(m_addr), 128'(32'h0000_4000));
        m_ready = 1; step(); clear_inputs(); step();

        // 6: m_ready while idle
        clear_counts();
        m_ready = 1; m_rhs = 1; m_whs = 1;
        step();
        step();
        clear_inputs();
        chk("t6_no_ready", 128'(i_ready_cnt + d_ready_cnt), 128'(0));
        chk("t6_idle", 128'(busy), 128'(0));

        // Randomized soak
        for (int n = 0; n < 2000; n++) begin
            i_valid = ($urandom_range(0, 9) < 6); d_valid = ($urandom_range(0, 9) < 6);
            i_req = 1'($urandom); d_req = 1'($urandom);
            i_addr = $urandom; d_addr = $urandom;
            i_size = 3'($urandom); d_size = 3'($urandom);
            i_len = 8'($urandom); d_len = 8'($urandom);
            i_wdata = {$urandom, $urandom}; d_wdata = {$urandom, $urandom};
            i_wstrb = 8'($urandom); d_wstrb = 8'($urandom);
            i_wlast = 1'($urandom); d_wlast = 1'($urandom);
            m_ready = ($urandom_range(0, 3) == 0);
            m_rdata = {$urandom, $urandom};
            m_rhs = 1'($urandom); m_rlast = 1'($urandom); m_whs = 1'($urandom);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
